// File: rtl/counter_ctrl.sv
// Start/pause/clear controller for a BCD stopwatch: two debounced pushbuttons drive
// a three-state run FSM and a divider that emits one count-enable pulse per TICK_DIV cycles.
module counter_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int TICK_DIV  = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_sp,
  input  logic       key_clr,
  output logic       s_p,
  output logic       clr,
  output logic       tick,
  output logic [1:0] state
);

  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  // Bit 0 carries the start/pause key, bit 1 the clear key.
  logic [1:0]            keys;
  logic [1:0]            meta_r;
  logic [1:0]            sync_r;
  logic [1:0]            lvl_r;
  logic [1:0]            lvl_d_r;
  logic [1:0][DB_W-1:0]  db_cnt_r;
  logic [1:0]            press;
  logic                  press_sp;
  logic                  press_clr;

  state_t                state_r;
  state_t                state_nxt;
  logic [DIV_W-1:0]      div_r;
  logic                  wrap;
  logic                  s_p_r;
  logic                  clr_r;
  logic                  tick_r;

  assign keys = {key_clr, key_sp};

  // Two-flop synchronizers; the idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 2'b11;
      sync_r <= 2'b11;
    end else begin
      meta_r <= keys;
      sync_r <= meta_r;
    end
  end

  // Debounce: a level is accepted only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_r    <= 2'b11;
      lvl_d_r  <= 2'b11;
      db_cnt_r <= '0;
    end else begin
      lvl_d_r <= lvl_r;
      for (int k = 0; k < 2; k++) begin
        if (sync_r[k] == lvl_r[k]) begin
          db_cnt_r[k] <= '0;
        end else if (db_cnt_r[k] == DB_LAST) begin
          lvl_r[k]    <= sync_r[k];
          db_cnt_r[k] <= '0;
        end else begin
          db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
        end
      end
    end
  end

  // A press is the single cycle following a debounced 1->0 change; releases are ignored.
  assign press     = lvl_d_r & ~lvl_r;
  assign press_sp  = press[0];
  assign press_clr = press[1];

  // Next-state logic; clear wins over start/pause, stray encodings fall back to IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (press_clr)     state_nxt = ST_IDLE;
        else if (press_sp) state_nxt = ST_RUN;
        else               state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (press_clr)     state_nxt = ST_IDLE;
        else if (press_sp) state_nxt = ST_PAUSE;
        else               state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (press_clr)     state_nxt = ST_IDLE;
        else if (press_sp) state_nxt = ST_RUN;
        else               state_nxt = ST_PAUSE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign wrap = (state_r == ST_RUN) && (div_r == DIV_LAST);

  // Tick divider: counts only while running, holds in PAUSE so partial intervals survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (state_nxt == ST_IDLE) begin
      div_r <= '0;
    end else if (state_r == ST_RUN) begin
      div_r <= wrap ? '0 : div_r + DIV_W'(1);
    end else begin
      div_r <= div_r;
    end
  end

  // State register and registered outputs; a wrap on the edge that leaves RUN gives no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      s_p_r   <= 1'b0;
      clr_r   <= 1'b1;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      s_p_r   <= (state_nxt == ST_RUN);
      clr_r   <= (state_nxt == ST_IDLE);
      tick_r  <= wrap && (state_nxt == ST_RUN);
    end
  end

  assign state = state_r;
  assign s_p   = s_p_r;
  assign clr   = clr_r;
  assign tick  = tick_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a cycle-level behavioural model checked every cycle.
module tb_counter_ctrl;

  localparam int DB = 4;
  localparam int TD = 10;

  logic       clk;
  logic       rst_n;
  logic       key_sp;
  logic       key_clr;
  logic       s_p;
  logic       clr;
  logic       tick;
  logic [1:0] state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  counter_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_sp  (key_sp),
    .key_clr (key_clr),
    .s_p     (s_p),
    .clr     (clr),
    .tick    (tick),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Model: keys pass a 2-sample delay, are accepted after DB differing samples,
  // an accepted press acts on the next edge, and ticks mark every TD-th cycle spent running.
  int m_meta_sp, m_sync_sp, m_acc_sp, m_run_sp, m_pend_sp;
  int m_meta_cl, m_sync_cl, m_acc_cl, m_run_cl, m_pend_cl;
  int m_state, m_runcyc, m_tick, m_nst;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_meta_sp = 1; m_sync_sp = 1; m_acc_sp = 1; m_run_sp = 0; m_pend_sp = 0;
      m_meta_cl = 1; m_sync_cl = 1; m_acc_cl = 1; m_run_cl = 0; m_pend_cl = 0;
      m_state = 0; m_runcyc = 0; m_tick = 0;
    end else begin
      m_nst = m_state;
      if (m_pend_cl != 0)      m_nst = 0;
      else if (m_pend_sp != 0) m_nst = (m_state == 1) ? 2 : 1;
      m_tick = 0;
      if (m_state == 1) begin
        m_runcyc++;
        if ((m_runcyc % TD) == 0 && m_nst == 1) m_tick = 1;
      end
      if (m_nst == 0) m_runcyc = 0;
      m_state = m_nst;

      m_pend_sp = 0;
      if (m_sync_sp == m_acc_sp) m_run_sp = 0;
      else begin
        m_run_sp++;
        if (m_run_sp == DB) begin
          m_acc_sp = m_sync_sp; m_run_sp = 0; m_pend_sp = (m_acc_sp == 0) ? 1 : 0;
        end
      end
      m_pend_cl = 0;
      if (m_sync_cl == m_acc_cl) m_run_cl = 0;
      else begin
        m_run_cl++;
        if (m_run_cl == DB) begin
          m_acc_cl = m_sync_cl; m_run_cl = 0; m_pend_cl = (m_acc_cl == 0) ? 1 : 0;
        end
      end

      m_sync_sp = m_meta_sp; m_meta_sp = int'(key_sp);
      m_sync_cl = m_meta_cl; m_meta_cl = int'(key_clr);
    end
  end

  logic [4:0] exp_vec;
  logic [4:0] act_vec;

  // Every-cycle comparison of {state, s_p, clr, tick} against the model.
  always @(negedge clk) begin
    exp_vec = {m_state[1:0], (m_state == 1), (m_state == 0), (m_tick != 0)};
    act_vec = {state, s_p, clr, tick};
    n_total++;
    if (act_vec === exp_vec) n_pass++;
    else $display("FAIL model_cmp cyc=%0d: got {state,s_p,clr,tick}=%b expected %b",
                  cyc, act_vec, exp_vec);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input int target, output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (int'(state) == target) begin
        at = cyc;
        break;
      end
    end
    chk(name, (at >= 0) ? 1 : 0, 1);
  endtask

  task automatic wait_tick(input string name, output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk(name, (at >= 0) ? 1 : 0, 1);
  endtask

  int t0, te, ta, tb, tc, td, tr, tq, nchg, ntk, ft;
  logic [1:0] prev;

  initial begin
    key_sp = 1'b1; key_clr = 1'b1; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", state, 0);
    chk("reset_s_p", s_p, 0);
    chk("reset_clr", clr, 1);
    chk("reset_tick", tick, 0);
    step(3);
    rst_n = 1'b1;

    // Glitches shorter than the debounce window are rejected.
    nchg = 0; prev = state;
    for (int r = 0; r < 3; r++) begin
      key_sp = 1'b0; step(3);
      key_sp = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step(1);
        if (state != prev) nchg++;
        prev = state;
      end
    end
    chk("glitch_state", state, 0);
    chk("glitch_changes", nchg, 0);

    // Start: 2 sync + 4 debounce + FSM edge.
    key_sp = 1'b0; t0 = cyc;
    wait_state("start_reached", 1, te);
    chk("start_latency_le8", (te - t0 <= 8) ? 1 : 0, 1);
    chk("start_s_p", s_p, 1);
    chk("start_clr", clr, 0);
    step(5); key_sp = 1'b1;
    wait_tick("tick1_seen", ta);
    chk("first_tick_delay", ta - te, TD);
    step(1);
    chk("tick_width", tick, 0);
    wait_tick("tick2_seen", tb);
    chk("tick_period", tb - ta, TD);

    // Pause so that 6 divider counts are banked (press acts 7 edges after the key falls).
    step(tb + 9 - cyc); key_sp = 1'b0;
    wait_state("pause_reached", 2, tq);
    chk("pause_edge", tq - tb, 16);
    chk("pause_tick", tick, 0);
    step(5); key_sp = 1'b1;
    ntk = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (tick === 1'b1) ntk++;
    end
    chk("pause_no_tick", ntk, 0);
    chk("pause_hold_state", state, 2);

    // Resume: the remaining 4 counts of the interrupted interval.
    key_sp = 1'b0;
    wait_state("resume_reached", 1, tr);
    wait_tick("resume_tick_seen", tc);
    chk("resume_first_tick", tc - tr, 4);
    step(1); key_sp = 1'b1;
    wait_tick("resume_tick2_seen", td);
    chk("resume_period", td - tc, TD);

    // Both keys at once while running: clear wins.
    key_sp = 1'b0; key_clr = 1'b0;
    wait_state("prio_reached", 0, te);
    chk("prio_clr", clr, 1);
    chk("prio_s_p", s_p, 0);
    chk("prio_tick", tick, 0);
    step(5); key_sp = 1'b1; key_clr = 1'b1;
    step(10);
    chk("prio_stays_idle", state, 0);

    // Long hold: exactly one start; divider restarts from zero.
    key_sp = 1'b0; nchg = 0; prev = state; te = -1; ft = -1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (state != prev) begin
        nchg++;
        if (state == 2'b01) te = cyc;
      end
      if (tick === 1'b1 && ft < 0) ft = cyc;
      prev = state;
    end
    key_sp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (state != prev) nchg++;
      prev = state;
    end
    chk("hold_changes", nchg, 1);
    chk("hold_state", state, 1);
    chk("hold_first_tick", ft - te, TD);
    key_sp = 1'b0;
    wait_state("repress_pause", 2, tq);
    step(5); key_sp = 1'b1; step(8);

    // Clear from PAUSE.
    key_clr = 1'b0;
    wait_state("clr_from_pause", 0, tq);
    chk("clr_level", clr, 1);
    step(5); key_clr = 1'b1; step(8);

    // Asynchronous reset in the middle of RUN, key held low through reset.
    key_sp = 1'b0;
    wait_state("run_before_reset", 1, te);
    step(5); key_sp = 1'b1; step(10);
    @(negedge clk); #2;
    rst_n = 1'b0; key_sp = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_s_p", s_p, 0);
    chk("async_rst_clr", clr, 1);
    chk("async_rst_tick", tick, 0);
    step(3);
    rst_n = 1'b1; t0 = cyc;
    wait_state("held_key_start", 1, te);
    chk("held_key_latency_le8", (te - t0 <= 8) ? 1 : 0, 1);
    nchg = 0; prev = state;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (state != prev) nchg++;
      prev = state;
    end
    chk("held_key_single_event", nchg, 0);
    key_sp = 1'b1;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
